// File: rtl/booth_radix8_accumulator_if.sv
// Operand/product handshake bundle for the radix-8 Booth multiplier.
// The master drives the operands and out_ready. The slave answers with in_ready and the product.
interface booth_radix8_accumulator_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_product;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_product
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_product
  );
endinterface

// File: rtl/booth_radix8_accumulator.sv
// Sequential radix-8 Booth multiplier for two 32-bit unsigned operands.
// An external encoder supplies one partial product per step, and the block accumulates 11 shifted terms.
module booth_radix8_accumulator (
  input  logic                              clk,
  input  logic                              rst,
  booth_radix8_accumulator_if.slave         bus,
  output logic [31:0]                       enc_data_o,
  output logic [3:0]                        enc_seg_o,
  input  logic [63:0]                       enc_pp_i,
  output logic                              busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic [33:0] seg_q, seg_d;
  logic [63:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  shamt;

  // The shift amount is 3*cnt, which is at most 30.
  assign shamt = {2'b00, cnt_q} + {1'b0, cnt_q, 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      seg_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      seg_q   <= seg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    seg_d   = seg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.in_a;
          seg_d   = {1'b0, bus.in_b, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_q + (enc_pp_i << shamt);
        seg_d = seg_q >> 3;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd10) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.out_product = (state_q == DONE) ? acc_q : 64'd0;
  assign busy            = (state_q == RUN) || (state_q == DONE);
  assign enc_data_o      = data_q;
  assign enc_seg_o       = (state_q == RUN) ? seg_q[3:0] : 4'b0000;
endmodule

// File: tb/tb_booth_radix8_accumulator.sv
// Directed bench for booth_radix8_accumulator with a behavioural radix-8 encoder.
module tb_booth_radix8_accumulator;
  logic        clk;
  logic        rst;
  logic [31:0] enc_data_o;
  logic [3:0]  enc_seg_o;
  logic [63:0] enc_pp_i;
  logic        busy;
  int          total;
  int          bad;
  logic [3:0]  seg_log [0:10];

  booth_radix8_accumulator_if bus ();

  booth_radix8_accumulator dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .enc_data_o (enc_data_o),
    .enc_seg_o  (enc_seg_o),
    .enc_pp_i   (enc_pp_i),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Encoder model: a signed multiple in {-4..+4} of the zero-extended multiplicand
  always_comb begin
    logic [63:0] m;
    m = {32'd0, enc_data_o};
    case (enc_seg_o)
      4'b0001, 4'b0010: enc_pp_i = m;
      4'b0011, 4'b0100: enc_pp_i = m * 64'd2;
      4'b0101, 4'b0110: enc_pp_i = m * 64'd3;
      4'b0111:          enc_pp_i = m * 64'd4;
      4'b1000:          enc_pp_i = -(m * 64'd4);
      4'b1001, 4'b1010: enc_pp_i = -(m * 64'd3);
      4'b1011, 4'b1100: enc_pp_i = -(m * 64'd2);
      4'b1101, 4'b1110: enc_pp_i = -m;
      default:          enc_pp_i = 64'd0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, 11 RUN cycles, optional DONE stall, handshake.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                        input int hold, input int inject_at);
    int edges;
    int waited;
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    check("in_ready_before_accept", {63'd0, bus.in_ready}, 64'd1);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    edges = 1;
    check("busy_after_accept", {63'd0, busy}, 64'd1);
    check("in_ready_in_run", {63'd0, bus.in_ready}, 64'd0);
    for (int i = 0; i <= 10; i++) begin
      seg_log[i] = enc_seg_o;
      if (i == 10) check("out_valid_low_last_run", {63'd0, bus.out_valid}, 64'd0);
      if (i == inject_at) begin
        bus.in_a     = 32'd2;
        bus.in_b     = 32'd2;
        bus.in_valid = 1'b1;
      end
      step();
      bus.in_valid = 1'b0;
      edges++;
    end
    check("edges_to_valid_incl_accept", edges, 64'd12);
    check("out_valid", {63'd0, bus.out_valid}, 64'd1);
    check("product", bus.out_product, exp);
    check("enc_data_latched", {32'd0, enc_data_o}, {32'd0, a});
    check("seg_zero_in_done", {60'd0, enc_seg_o}, 64'd0);
    for (int k = 0; k < hold; k++) begin
      step();
      check("out_valid_hold", {63'd0, bus.out_valid}, 64'd1);
      check("product_hold", bus.out_product, exp);
      check("in_ready_hold", {63'd0, bus.in_ready}, 64'd0);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("in_ready_after_handshake", {63'd0, bus.in_ready}, 64'd1);
    check("product_zero_idle", bus.out_product, 64'd0);
    check("busy_idle", {63'd0, busy}, 64'd0);
    $display("op a=%h b=%h product_expected=%h", a, b, exp);
  endtask

  initial begin
    logic [3:0] exp_seg [0:10];
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = 32'd0;
    bus.in_b      = 32'd0;
    bus.out_ready = 1'b0;
    repeat (2) step();
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_product", bus.out_product, 64'd0);
    rst = 1'b0;

    // 3*5: segments 1010 (-3a), 0001 (+a << 3), then zeros
    run_op(32'd3, 32'd5, 64'd15, 0, -1);
    for (int i = 0; i <= 10; i++) exp_seg[i] = 4'b0000;
    exp_seg[0] = 4'b1010;
    exp_seg[1] = 4'b0001;
    for (int i = 0; i <= 10; i++) begin
      check($sformatf("seg_step%0d", i), {60'd0, seg_log[i]}, {60'd0, exp_seg[i]});
    end

    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 0, -1);
    run_op(32'd1, 32'hFFFFFFFF, 64'h00000000FFFFFFFF, 0, -1);
    run_op(32'h12345678, 32'd0, 64'd0, 0, -1);
    run_op(32'd7, 32'd9, 64'd63, 5, -1);
    run_op(32'd10, 32'd10, 64'd100, 0, 4);

    // Asynchronous reset in the middle of RUN
    bus.in_a     = 32'd9;
    bus.in_b     = 32'd9;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (5) step();
    check("mid_run_busy", {63'd0, busy}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("async_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("async_rst_busy", {63'd0, busy}, 64'd0);
    check("async_rst_product", bus.out_product, 64'd0);
    check("async_rst_seg", {60'd0, enc_seg_o}, 64'd0);
    check("async_rst_data", {32'd0, enc_data_o}, 64'd0);
    #1 rst = 1'b0;
    run_op(32'd6, 32'd7, 64'd42, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
